// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: field widths, opcodes, and the ID/EX bundle.
package mips_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned SHAMT_W  = 5;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;

    // Instructions whose rt field names a source register rather than a destination.
    function automatic logic uses_rt(input logic [OPCODE_W-1:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_SW) ||
               (opcode == OP_BEQ)   || (opcode == OP_BNE);
    endfunction

    typedef struct packed {
        logic                valid;
        logic [DATA_W-1:0]   pc;
        logic [OPCODE_W-1:0] opcode;
        logic [FUNCT_W-1:0]  funct;
        logic [SHAMT_W-1:0]  shamt;
        logic [ADDR_W-1:0]   rs_addr;
        logic [ADDR_W-1:0]   rt_addr;
        logic [ADDR_W-1:0]   rd_addr;
        logic [DATA_W-1:0]   rs_data;
        logic [DATA_W-1:0]   rt_data;
        logic [DATA_W-1:0]   imm_sext;
    } id_ex_t;

endpackage

// File: rtl/operand_bypass.sv
// Picks one source operand: $zero forcing, then same-cycle writeback bypass, then RF data.
module operand_bypass #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              wb_write_en,
    input  logic [ADDR_W-1:0] wb_write_address,
    input  logic [DATA_W-1:0] wb_write_data,
    output logic [DATA_W-1:0] operand_c
);

    always_comb begin
        operand_c = rf_data;
        if (addr == '0) begin
            operand_c = '0;
        end else if (wb_write_en && (wb_write_address == addr)) begin
            operand_c = wb_write_data;
        end
    end

endmodule

// File: rtl/decode_operand_stage.sv
// MIPS ID stage: operand fetch with writeback bypass, load-use bubbles, stall and flush.
module decode_operand_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [DATA_W-1:0] if_instr,
    input  logic [DATA_W-1:0] if_pc,
    output logic              if_stall,
    output logic [ADDR_W-1:0] read_address_0,
    output logic [ADDR_W-1:0] read_address_1,
    input  logic [DATA_W-1:0] read_data_0,
    input  logic [DATA_W-1:0] read_data_1,
    input  logic              wb_write_en,
    input  logic [ADDR_W-1:0] wb_write_address,
    input  logic [DATA_W-1:0] wb_write_data,
    input  logic              ex_mem_read,
    input  logic [ADDR_W-1:0] ex_dest_address,
    input  logic              ex_ready,
    input  logic              flush,
    output logic              id_valid,
    output logic [DATA_W-1:0] id_pc,
    output logic [5:0]        id_opcode,
    output logic [5:0]        id_funct,
    output logic [4:0]        id_shamt,
    output logic [ADDR_W-1:0] id_rs_addr,
    output logic [ADDR_W-1:0] id_rt_addr,
    output logic [ADDR_W-1:0] id_rd_addr,
    output logic [DATA_W-1:0] id_rs_data,
    output logic [DATA_W-1:0] id_rt_data,
    output logic [DATA_W-1:0] id_imm_sext,
    output logic [CNT_W-1:0]  bubble_count
);
    import mips_pkg::*;

    logic [ADDR_W-1:0] rs_c;
    logic [ADDR_W-1:0] rt_c;
    logic [DATA_W-1:0] rs_data_c;
    logic [DATA_W-1:0] rt_data_c;
    logic              hazard_c;
    id_ex_t            id_next_c;
    id_ex_t            id_q;

    assign rs_c           = if_instr[25:21];
    assign rt_c           = if_instr[20:16];
    assign read_address_0 = rs_c;
    assign read_address_1 = rt_c;

    operand_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rs_bypass (
        .addr             (rs_c),
        .rf_data          (read_data_0),
        .wb_write_en      (wb_write_en),
        .wb_write_address (wb_write_address),
        .wb_write_data    (wb_write_data),
        .operand_c        (rs_data_c)
    );

    operand_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rt_bypass (
        .addr             (rt_c),
        .rf_data          (read_data_1),
        .wb_write_en      (wb_write_en),
        .wb_write_address (wb_write_address),
        .wb_write_data    (wb_write_data),
        .operand_c        (rt_data_c)
    );

    // A load in EX whose result this instruction needs cannot be forwarded in time.
    always_comb begin
        hazard_c = if_valid && ex_mem_read && (ex_dest_address != '0) &&
                   ((ex_dest_address == rs_c) ||
                    (uses_rt(if_instr[31:26]) && (ex_dest_address == rt_c)));
    end

    // Flush outranks everything: the killed instruction must not hold up fetch.
    always_comb begin
        if_stall = 1'b0;
        if (!flush && (!ex_ready || hazard_c)) begin
            if_stall = 1'b1;
        end
    end

    always_comb begin
        id_next_c          = '0;
        id_next_c.valid    = if_valid;
        id_next_c.pc       = if_pc;
        id_next_c.opcode   = if_instr[31:26];
        id_next_c.funct    = if_instr[5:0];
        id_next_c.shamt    = if_instr[10:6];
        id_next_c.rs_addr  = rs_c;
        id_next_c.rt_addr  = rt_c;
        id_next_c.rd_addr  = if_instr[15:11];
        id_next_c.rs_data  = rs_data_c;
        id_next_c.rt_data  = rt_data_c;
        id_next_c.imm_sext = {{(DATA_W-16){if_instr[15]}}, if_instr[15:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_q         <= '0;
            bubble_count <= '0;
        end else if (flush) begin
            id_q.valid <= 1'b0;
        end else if (!ex_ready) begin
            id_q <= id_q;
        end else if (hazard_c) begin
            id_q.valid <= 1'b0;
            if (bubble_count != '1) begin
                bubble_count <= bubble_count + CNT_W'(1);
            end
        end else begin
            id_q <= id_next_c;
        end
    end

    assign id_valid    = id_q.valid;
    assign id_pc       = id_q.pc;
    assign id_opcode   = id_q.opcode;
    assign id_funct    = id_q.funct;
    assign id_shamt    = id_q.shamt;
    assign id_rs_addr  = id_q.rs_addr;
    assign id_rt_addr  = id_q.rt_addr;
    assign id_rd_addr  = id_q.rd_addr;
    assign id_rs_data  = id_q.rs_data;
    assign id_rt_data  = id_q.rt_data;
    assign id_imm_sext = id_q.imm_sext;

endmodule

// File: tb/tb_decode_operand_stage.sv
// Directed bench for decode_operand_stage: vector table plus stall, flush and saturation sequences.
module tb_decode_operand_stage;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_valid;
    logic [DATA_W-1:0] if_instr;
    logic [DATA_W-1:0] if_pc;
    logic              if_stall;
    logic [ADDR_W-1:0] read_address_0;
    logic [ADDR_W-1:0] read_address_1;
    logic [DATA_W-1:0] read_data_0;
    logic [DATA_W-1:0] read_data_1;
    logic              wb_write_en;
    logic [ADDR_W-1:0] wb_write_address;
    logic [DATA_W-1:0] wb_write_data;
    logic              ex_mem_read;
    logic [ADDR_W-1:0] ex_dest_address;
    logic              ex_ready;
    logic              flush;
    logic              id_valid;
    logic [DATA_W-1:0] id_pc;
    logic [5:0]        id_opcode;
    logic [5:0]        id_funct;
    logic [4:0]        id_shamt;
    logic [ADDR_W-1:0] id_rs_addr;
    logic [ADDR_W-1:0] id_rt_addr;
    logic [ADDR_W-1:0] id_rd_addr;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm_sext;
    logic [CNT_W-1:0]  bubble_count;

    logic [DATA_W-1:0] rf [32];

    always #5 clk = ~clk;

    assign read_data_0 = rf[read_address_0];
    assign read_data_1 = rf[read_address_1];

    decode_operand_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .if_valid         (if_valid),
        .if_instr         (if_instr),
        .if_pc            (if_pc),
        .if_stall         (if_stall),
        .read_address_0   (read_address_0),
        .read_address_1   (read_address_1),
        .read_data_0      (read_data_0),
        .read_data_1      (read_data_1),
        .wb_write_en      (wb_write_en),
        .wb_write_address (wb_write_address),
        .wb_write_data    (wb_write_data),
        .ex_mem_read      (ex_mem_read),
        .ex_dest_address  (ex_dest_address),
        .ex_ready         (ex_ready),
        .flush            (flush),
        .id_valid         (id_valid),
        .id_pc            (id_pc),
        .id_opcode        (id_opcode),
        .id_funct         (id_funct),
        .id_shamt         (id_shamt),
        .id_rs_addr       (id_rs_addr),
        .id_rt_addr       (id_rt_addr),
        .id_rd_addr       (id_rd_addr),
        .id_rs_data       (id_rs_data),
        .id_rt_data       (id_rt_data),
        .id_imm_sext      (id_imm_sext),
        .bubble_count     (bubble_count)
    );

    int total = 0;
    int bad   = 0;
    int exp_bubbles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] sext16(input logic [31:0] instr);
        return {{16{instr[15]}}, instr[15:0]};
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= 15) ? 15 : v + 1;
    endfunction

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        ld;
        logic [4:0]  ld_dst;
        logic        exp_stall;
        logic        exp_valid;
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;
    } vec_t;

    vec_t vecs[$];

    task automatic drive_idle();
        if_valid         = 1'b0;
        if_instr         = '0;
        if_pc            = '0;
        wb_write_en      = 1'b0;
        wb_write_address = '0;
        wb_write_data    = '0;
        ex_mem_read      = 1'b0;
        ex_dest_address  = '0;
        ex_ready         = 1'b1;
        flush            = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] add_389;
        logic [31:0] held_pc;
        logic [31:0] held_rs;

        for (int i = 0; i < 32; i++) rf[i] = 32'hA000_0000 | 32'(i);
        rf[0] = 32'hDEAD_0000;
        rf[8] = 32'h0000_0011;
        add_389 = rtype(8, 9, 3, 32'h20);

        // Reset with a valid instruction presented.
        drive_idle();
        rst = 1'b1;
        if_valid = 1'b1;
        if_instr = add_389;
        if_pc = 32'h40;
        tick();
        tick();
        check("rst_stall",  32'(if_stall), 32'h0);
        check("rst_valid",  32'(id_valid), 32'h0);
        check("rst_pc",     id_pc, 32'h0);
        check("rst_opcode", 32'(id_opcode), 32'h0);
        check("rst_funct",  32'(id_funct), 32'h0);
        check("rst_shamt",  32'(id_shamt), 32'h0);
        check("rst_rsaddr", 32'(id_rs_addr), 32'h0);
        check("rst_rtaddr", 32'(id_rt_addr), 32'h0);
        check("rst_rdaddr", 32'(id_rd_addr), 32'h0);
        check("rst_rsdata", id_rs_data, 32'h0);
        check("rst_rtdata", id_rt_data, 32'h0);
        check("rst_imm",    id_imm_sext, 32'h0);
        check("rst_bubble", 32'(bubble_count), 32'h0);
        rst = 1'b0;

        vecs.push_back('{"add_plain", add_389, 32'h100, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                         1'b0, 1'b1, 32'h11, 32'hA000_0009});
        vecs.push_back('{"add_wb_rs", add_389, 32'h104, 1'b1, 1'b1, 5'd8, 32'hCAFE, 1'b0, 5'd0,
                         1'b0, 1'b1, 32'hCAFE, 32'hA000_0009});
        vecs.push_back('{"zero_rs", rtype(0, 9, 3, 32'h20), 32'h108, 1'b1, 1'b1, 5'd0, 32'hBEEF, 1'b0, 5'd0,
                         1'b0, 1'b1, 32'h0, 32'hA000_0009});
        vecs.push_back('{"wb_off", add_389, 32'h10C, 1'b1, 1'b0, 5'd9, 32'h1234, 1'b0, 5'd0,
                         1'b0, 1'b1, 32'h11, 32'hA000_0009});
        vecs.push_back('{"wb_rt", add_389, 32'h110, 1'b1, 1'b1, 5'd9, 32'h1234, 1'b0, 5'd0,
                         1'b0, 1'b1, 32'h11, 32'h1234});
        vecs.push_back('{"ori_rt_dst", itype(32'h0D, 4, 8, 32'h8001), 32'h114, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd8,
                         1'b0, 1'b1, 32'hA000_0004, 32'h11});
        vecs.push_back('{"sw_hazard", itype(32'h2B, 2, 8, 32'h4), 32'h118, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd8,
                         1'b1, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{"sw_release", itype(32'h2B, 2, 8, 32'h4), 32'h118, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd8,
                         1'b0, 1'b1, 32'hA000_0002, 32'h11});
        vecs.push_back('{"ld_dst_zero", rtype(0, 9, 3, 32'h20), 32'h11C, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0,
                         1'b0, 1'b1, 32'h0, 32'hA000_0009});
        vecs.push_back('{"invalid_no_haz", add_389, 32'h120, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd8,
                         1'b0, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{"add_hazard", add_389, 32'h124, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd8,
                         1'b1, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{"beq_rt_haz", itype(32'h04, 5, 8, 32'hFFFE), 32'h128, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd8,
                         1'b1, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{"addi_rs_haz", itype(32'h08, 8, 7, 32'h10), 32'h12C, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd8,
                         1'b1, 1'b0, 32'h0, 32'h0});
        vecs.push_back('{"bne_imm_neg", itype(32'h05, 6, 9, 32'hFFF0), 32'h130, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7,
                         1'b0, 1'b1, 32'hA000_0006, 32'hA000_0009});

        foreach (vecs[i]) begin
            if_valid         = vecs[i].valid;
            if_instr         = vecs[i].instr;
            if_pc            = vecs[i].pc;
            wb_write_en      = vecs[i].wb_en;
            wb_write_address = vecs[i].wb_addr;
            wb_write_data    = vecs[i].wb_data;
            ex_mem_read      = vecs[i].ld;
            ex_dest_address  = vecs[i].ld_dst;
            #1;
            check({vecs[i].name, "_stall"}, 32'(if_stall), 32'(vecs[i].exp_stall));
            check({vecs[i].name, "_ra0"}, 32'(read_address_0), 32'(vecs[i].instr[25:21]));
            if (vecs[i].exp_stall) exp_bubbles = sat_inc(exp_bubbles);
            tick();
            check({vecs[i].name, "_valid"}, 32'(id_valid), 32'(vecs[i].exp_valid));
            check({vecs[i].name, "_bubble"}, 32'(bubble_count), 32'(exp_bubbles));
            if (vecs[i].exp_valid) begin
                check({vecs[i].name, "_pc"}, id_pc, vecs[i].pc);
                check({vecs[i].name, "_rs"}, id_rs_data, vecs[i].exp_rs);
                check({vecs[i].name, "_rt"}, id_rt_data, vecs[i].exp_rt);
                check({vecs[i].name, "_imm"}, id_imm_sext, sext16(vecs[i].instr));
                check({vecs[i].name, "_op"}, 32'(id_opcode), 32'(vecs[i].instr[31:26]));
                check({vecs[i].name, "_rd"}, 32'(id_rd_addr), 32'(vecs[i].instr[15:11]));
            end
        end

        // Downstream stall: capture one instruction, then hold it for three cycles.
        drive_idle();
        if_valid = 1'b1;
        if_instr = rtype(10, 11, 12, 32'h22) | 32'h0000_0140;
        if_pc    = 32'h200;
        tick();
        check("hold_load_pc", id_pc, 32'h200);
        check("hold_shamt", 32'(id_shamt), 32'd5);
        check("hold_funct", 32'(id_funct), 32'h22);
        held_pc = 32'h200;
        held_rs = 32'hA000_000A;
        if_instr = add_389;
        if_pc    = 32'h204;
        ex_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            wb_write_en      = (c == 2);
            wb_write_address = 5'd8;
            wb_write_data    = 32'h5555_0008;
            #1;
            check("hold_stall", 32'(if_stall), 32'h1);
            tick();
            check("hold_valid", 32'(id_valid), 32'h1);
            check("hold_pc", id_pc, held_pc);
            check("hold_rs", id_rs_data, held_rs);
        end
        // Writeback lands while stalled; release cycle re-reads the updated register.
        rf[8] = 32'h5555_0008;
        wb_write_en = 1'b0;
        ex_ready = 1'b1;
        #1;
        check("release_stall", 32'(if_stall), 32'h0);
        tick();
        check("release_pc", id_pc, 32'h204);
        check("release_rs", id_rs_data, 32'h5555_0008);
        check("release_valid", 32'(id_valid), 32'h1);

        // Flush beats both downstream stall and a pending load-use hazard.
        ex_ready        = 1'b0;
        flush           = 1'b1;
        ex_mem_read     = 1'b1;
        ex_dest_address = 5'd8;
        #1;
        check("flush_stall", 32'(if_stall), 32'h0);
        tick();
        check("flush_valid", 32'(id_valid), 32'h0);
        check("flush_bubble", 32'(bubble_count), 32'(exp_bubbles));

        // Saturation: keep the hazard up long enough to wrap a 4-bit counter.
        flush    = 1'b0;
        ex_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            exp_bubbles = sat_inc(exp_bubbles);
            tick();
        end
        check("sat_value", 32'(bubble_count), 32'hF);
        check("sat_model", 32'(bubble_count), 32'(exp_bubbles));
        check("sat_stall", 32'(if_stall), 32'h1);
        tick();
        check("sat_hold", 32'(bubble_count), 32'hF);
        check("sat_valid", 32'(id_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_operand_stage.md
Name: decode_operand_stage

Overview:
- ID stage of the 5-stage MIPS pipeline; sits between the IF/ID register and the ID/EX register.
- Drives the register file read addresses and captures the returned operands into a registered ID/EX output bundle.
- Applies same-cycle writeback bypass and $zero forcing to the captured operands.
- Detects load-use hazards, inserts bubbles, and honours downstream stall and branch flush.

Parameters:
- DATA_W, 32, datapath width
- ADDR_W, 5, register address width
- CNT_W, 32, bubble counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- if_valid  in  1  IF/ID holds a valid instruction
- if_instr  in  DATA_W  instruction word
- if_pc  in  DATA_W  PC of instruction
- if_stall  out  1  hold IF/ID and PC (combinational)
- read_address_0  out  ADDR_W  to register file, = instr[25:21] (rs)
- read_address_1  out  ADDR_W  to register file, = instr[20:16] (rt)
- read_data_0  in  DATA_W  register file rs data (combinational read)
- read_data_1  in  DATA_W  register file rt data
- wb_write_en  in  1  snoop of register file write enable
- wb_write_address  in  ADDR_W  snoop of write address
- wb_write_data  in  DATA_W  snoop of write data
- ex_mem_read  in  1  instruction now in EX is a load
- ex_dest_address  in  ADDR_W  load destination in EX
- ex_ready  in  1  EX accepts ID/EX this cycle
- flush  in  1  branch/jump taken, kill younger instruction
- id_valid  out  1  ID/EX entry valid
- id_pc  out  DATA_W
- id_opcode  out  6
- id_funct  out  6
- id_shamt  out  5
- id_rs_addr, id_rt_addr, id_rd_addr  out  ADDR_W each
- id_rs_data, id_rt_data  out  DATA_W each
- id_imm_sext  out  DATA_W  sign-extended instr[15:0]
- bubble_count  out  CNT_W  load-use bubbles inserted, saturating

Behaviour:
- Reset (sync): all id_* registers and bubble_count are 0. if_stall is combinational and follows the rules below during reset.
- read_address_0/1 are combinational slices of if_instr, always driven.
- Operand selection, per port:
  - address 0 → operand is 0.
  - else wb_write_en && wb_write_address == address → wb_write_data.
  - else register file data.
- uses_rt = opcode in {0x00 R-type, 0x2B sw, 0x04 beq, 0x05 bne}. rs is always treated as used.
- hazard = if_valid && ex_mem_read && ex_dest_address != 0 && (ex_dest_address == rs || (uses_rt && ex_dest_address == rt)).
- Per-edge priority, highest first:
  1. rst.
  2. flush: id_valid <= 0, other id_* don't-care, if_stall = 0.
  3. !ex_ready: all id_* hold, if_stall = 1.
  4. hazard: id_valid <= 0 (bubble), if_stall = 1, bubble_count += 1 saturating at all-ones.
  5. advance: id_* <= decoded fields and operands, id_valid <= if_valid, if_stall = 0.
- Latency: one cycle from IF/ID to ID/EX.
- While stalled, the operands are re-read every cycle, so a writeback landing during the stall is picked up.
- Hazard is re-evaluated every cycle. Once the load leaves EX, the instruction advances; MEM-stage forwarding is not this block's job.
- id_valid = 0 entries are ignored downstream. Their id_* data fields are don't-care, except during reset (all 0).

Decomposition:
- Shared package mips_pkg:
  - opcode constants (OP_RTYPE, OP_SW, OP_BEQ, OP_BNE, OP_LW)
  - DATA_W/ADDR_W constants
  - uses_rt function
  - ID/EX bundle typedef
- One natural sub-module: operand_bypass (address, rf data, wb snoop → operand), instantiated twice.

Test Plan:
- Reset: assert rst 2 cycles with if_valid = 1 → id_valid = 0, all id_* = 0, bubble_count = 0.
- Bypass: RF[8] = 0x11; add $3,$8,$9 in ID, same cycle wb writes $8 = 0xCAFE → id_rs_data = 0xCAFE next cycle. Repeat with wb_write_address = 0 and rs = 0 → id_rs_data = 0.
- Load-use: ex_mem_read = 1, ex_dest_address = 8, ID holds add using $8.
  - Cycle 1: if_stall = 1, id_valid = 0 next edge, bubble_count = 1.
  - Next cycle, ex_mem_read = 0: instruction advances.
  - Same case with ori $8-target-in-rt (uses_rt = 0) → no stall.
- Downstream stall: ex_ready = 0 for 3 cycles → id_* unchanged, if_stall = 1; ex_ready = 1 → new instruction captured.
- Flush priority: flush = 1 while ex_ready = 0 and hazard = 1 → id_valid = 0, if_stall = 0, bubble_count unchanged.
- Saturation: force bubble_count to all-ones (CNT_W = 4 build) and generate a hazard → stays 0xF.
